// File: rtl/wb_pkg.sv
// Shared types for the register-file writeback arbiter: source select,
// starvation FSM states and the hard-wired zero register address.
package wb_pkg;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_PIPE,
        SRC_QUEUE
    } wb_src_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        STARVED
    } wb_fsm_e;

    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/wb_queue.sv
// Small compacting FIFO for long-latency results. Entries whose address
// matches the kill address are dropped and survivors slide toward the head.
module wb_queue
    import wb_pkg::*;
#(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int QDEPTH = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [AW-1:0]             push_rdc,
    input  logic [DW-1:0]             push_data,
    input  logic                      pop,
    input  logic                      kill_en,
    input  logic [AW-1:0]             kill_rdc,
    output logic [$clog2(QDEPTH):0]   count,
    output logic [$clog2(QDEPTH):0]   count_next,
    output logic                      head_valid,
    output logic [AW-1:0]             head_rdc,
    output logic [DW-1:0]             head_data,
    output logic                      head_killed
);

    localparam int IW = $clog2(QDEPTH);
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

    logic [QDEPTH-1:0] vld_q, vld_d;
    logic [AW-1:0]     rdc_q  [QDEPTH];
    logic [AW-1:0]     rdc_d  [QDEPTH];
    logic [DW-1:0]     data_q [QDEPTH];
    logic [DW-1:0]     data_d [QDEPTH];
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     n;

    // Survivors are gathered in age order; a new entry lands behind them.
    always_comb begin
        rdc_d  = rdc_q;
        data_d = data_q;
        vld_d  = '0;
        n      = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            if (vld_q[i] && !(pop && i == 0) && !(kill_en && rdc_q[i] == kill_rdc)) begin
                rdc_d[n[IW-1:0]]  = rdc_q[i];
                data_d[n[IW-1:0]] = data_q[i];
                vld_d[n[IW-1:0]]  = 1'b1;
                n = n + 1'b1;
            end
        end
        if (push && !(kill_en && push_rdc == kill_rdc) && n < DEPTH_C) begin
            rdc_d[n[IW-1:0]]  = push_rdc;
            data_d[n[IW-1:0]] = push_data;
            vld_d[n[IW-1:0]]  = 1'b1;
            n = n + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                rdc_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            vld_q   <= vld_d;
            count_q <= n;
            rdc_q   <= rdc_d;
            data_q  <= data_d;
        end
    end

    assign count       = count_q;
    assign count_next  = n;
    assign head_valid  = vld_q[0];
    assign head_rdc    = rdc_q[0];
    assign head_data   = data_q[0];
    assign head_killed = kill_en && vld_q[0] && (rdc_q[0] == kill_rdc);

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write port owner: merges the unstallable pipeline writeback
// with queued long-latency results and asks for a bubble when they starve.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DW           = 32,
    parameter int AW           = 5,
    parameter int QDEPTH       = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pipe_valid,
    input  logic                    pipe_is_load,
    input  logic [AW-1:0]           pipe_rdc,
    input  logic [DW-1:0]           pipe_alu,
    input  logic [DW-1:0]           pipe_data,
    input  logic                    mdu_valid,
    output logic                    mdu_ready,
    input  logic [AW-1:0]           mdu_rdc,
    input  logic [DW-1:0]           mdu_data,
    output logic                    wen,
    output logic [AW-1:0]           rdc,
    output logic [DW-1:0]           rdd,
    output logic [$clog2(QDEPTH):0] q_count,
    output logic                    stall_req
);

    localparam int CW = $clog2(QDEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);
    localparam logic [CW-1:0] DEPTH_C   = CW'(QDEPTH);
    localparam logic [SW-1:0] LIMIT_C   = SW'(STARVE_LIMIT);

    wb_src_e       sel;
    wb_fsm_e       state_q, state_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic          stall_d;
    logic          push, pop, kill_en;
    logic [CW-1:0] count_next;
    logic          head_valid, head_killed;
    logic [AW-1:0] head_rdc;
    logic [DW-1:0] head_data;

    // Ready depends only on the registered count, so a pop cannot free a slot early.
    assign mdu_ready = (q_count < DEPTH_C);
    assign push      = mdu_valid && mdu_ready && (mdu_rdc != ZERO_ADDR);
    assign kill_en   = pipe_valid && (pipe_rdc != ZERO_ADDR);
    assign pop       = (sel == SRC_QUEUE);

    wb_queue #(
        .DW     (DW),
        .AW     (AW),
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .push_rdc    (mdu_rdc),
        .push_data   (mdu_data),
        .pop         (pop),
        .kill_en     (kill_en),
        .kill_rdc    (pipe_rdc),
        .count       (q_count),
        .count_next  (count_next),
        .head_valid  (head_valid),
        .head_rdc    (head_rdc),
        .head_data   (head_data),
        .head_killed (head_killed)
    );

    always_comb begin
        sel = SRC_NONE;
        if (pipe_valid) begin
            sel = SRC_PIPE;
        end else if (head_valid) begin
            sel = SRC_QUEUE;
        end
    end

    // A pipe write to r0 burns the slot but leaves the port registers untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wen <= 1'b0;
            rdc <= '0;
            rdd <= '0;
        end else begin
            case (sel)
                SRC_PIPE: begin
                    wen <= (pipe_rdc != ZERO_ADDR);
                    if (pipe_rdc != ZERO_ADDR) begin
                        rdc <= pipe_rdc;
                        rdd <= pipe_is_load ? pipe_data : pipe_alu;
                    end
                end
                SRC_QUEUE: begin
                    wen <= 1'b1;
                    rdc <= head_rdc;
                    rdd <= head_data;
                end
                default: wen <= 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            stall_req <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stall_req <= stall_d;
        end
    end

    // The counter measures how long the current head has gone unserved.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (count_next != '0) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (pop || head_killed) begin
                    cnt_d   = '0;
                    state_d = (count_next == '0) ? IDLE : WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == LIMIT_C) begin
                        state_d = STARVED;
                    end
                end
            end
            STARVED: begin
                if (pop || head_killed) begin
                    cnt_d   = '0;
                    state_d = (count_next == '0) ? IDLE : WAIT;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        stall_d = (state_d == STARVED);
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Owns the register-file write port (wen/rdc/rdd) and merges two writeback sources.
- Source 1 is the in-order pipeline MEM→WB path. It carries ALU results or load data and can never be stalled.
- Source 2 is a long-latency unit (mul/div) that hands results over through a valid/ready handshake into a small kill-able queue.
- Sits between the MEM/WB boundary and the register file. Drives the write port the register file samples on posedge clk, and raises a stall request to hazard control when queued results are starved.

Parameters:
- DW, 32, data width.
- AW, 5, register address width.
- QDEPTH, 2, long-latency result queue depth (power of 2, ≥2).
- STARVE_LIMIT, 4, cycles a queue head may wait before stall_req asserts.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- pipe_valid  in  1  pipeline instruction in MEM has a register result
- pipe_is_load  in  1  1: write pipe_data; 0: write pipe_alu
- pipe_rdc  in  AW  pipeline destination register
- pipe_alu  in  DW  ALU result (ALUo_MEM)
- pipe_data  in  DW  load data (Data_MEM)
- mdu_valid  in  1  long-latency result offered
- mdu_ready  out  1  queue can accept
- mdu_rdc  in  AW  long-latency destination
- mdu_data  in  DW  long-latency result
- wen  out  1  register-file write enable
- rdc  out  AW  register-file write address
- rdd  out  DW  register-file write data
- q_count  out  $clog2(QDEPTH)+1  valid queue entries
- stall_req  out  1  request pipeline bubble so the queue can drain

Behaviour:
- Reset (reset=0, async):
  - wen=0, rdc=0, rdd=0.
  - Queue emptied, q_count=0, stall_req=0, FSM=IDLE, starve counter=0.
  - mdu_ready=1 from the first cycle after release.
- Write port is registered. wen/rdc/rdd update on posedge clk from the selection made in the preceding cycle.
- Pipeline latency: pipe_valid in cycle N → wen=1 in cycle N+1.
- Long-latency latency:
  - Handshake (mdu_valid&&mdu_ready) in cycle N → entry valid in N+1.
  - If selected in N+1, wen=1 in N+2.
  - No bypass around the queue.
- Selection per cycle:
  - pipe_valid has absolute priority.
  - Otherwise the valid queue head is popped and written.
  - Otherwise wen=0 next cycle; rdc/rdd hold their last values.
- Register 0:
  - A pipe write with pipe_rdc=0 produces wen=0 but still occupies the slot (no queue pop).
  - A handshake with mdu_rdc=0 is accepted and discarded (not enqueued).
- mdu_ready = (q_count < QDEPTH), computed from the registered count only. When full, no enqueue occurs even if a pop happens the same cycle.
- WAW kill:
  - When pipe_valid with pipe_rdc≠0 is presented, every queue entry with rdc==pipe_rdc is invalidated in the same cycle. This includes an entry being enqueued that cycle.
  - The pipeline result is always younger.
  - Killed entries are compacted out; q_count reflects survivors next cycle.
- Queue order among surviving entries is FIFO.
- Simultaneous enqueue+pop (not full): q_count unchanged; the new entry goes behind the popped head.
- Starvation FSM:
  - IDLE: queue empty. Go to WAIT when q_count becomes nonzero.
  - WAIT:
    - The counter increments each cycle the head exists but is not popped.
    - On a pop, the counter clears; go to IDLE if the queue is now empty, else stay in WAIT.
    - When the counter reaches STARVE_LIMIT, go to STARVED.
  - STARVED:
    - stall_req=1 (registered).
    - Hazard control must deassert pipe_valid next cycle; the head pops.
    - Leave to WAIT or IDLE on pop, or when the head is killed, with counter cleared and stall_req=0 the following cycle.
- If pipe_valid is still asserted while in STARVED, the pipe write still wins (protocol error; no data loss or corruption permitted).

Decomposition:
- Shared package wb_pkg holds:
  - wb_src_e (SRC_NONE, SRC_PIPE, SRC_QUEUE)
  - wb_fsm_e (IDLE, WAIT, STARVED)
  - the reg-0 address constant REG_ZERO
- One sub-module wb_queue: parameterised FIFO with per-entry valid, match-and-kill on an address, compaction, push/pop, count.
- Arbitration, output register and starvation FSM stay in wb_arbiter.

Test Plan:
- Reset: hold reset=0 for 3 cycles with random inputs → wen=0, q_count=0, stall_req=0, mdu_ready=1; release → mdu_ready=1.
- Pipe path: pipe_valid=1, rdc=8, pipe_is_load=0, pipe_alu=0x1234 in cycle N → cycle N+1 wen=1, rdc=8, rdd=0x1234; repeat with is_load=1, pipe_data=0xDEADBEEF → rdd=0xDEADBEEF.
- Queue path: mdu handshake rdc=9, data=0x55 with pipe idle → wen=1, rdc=9, rdd=0x55 exactly 2 cycles later; mdu_rdc=0 accepted → no write, q_count stays 0.
- Backpressure: two handshakes (rdc 3, 4) while pipe_valid held high with rdc=5 → q_count=2, mdu_ready=0; drop pipe_valid → writes 3 then 4 in order, mdu_ready returns to 1.
- WAW kill: queue holds rdc=7 data=0xAA; pipe writes rdc=7 data=0xBB → single write of 0xBB, q_count=0, no later write of 0xAA.
- Starvation: queue holds one entry, pipe_valid held high for STARVE_LIMIT cycles → stall_req=1; drop pipe_valid one cycle → entry written, stall_req=0 the following cycle.
